// File: rtl/l1i_cache_pkg.sv
// l1i_cache_pkg -- shared widths and FSM encoding for the L1 instruction cache.
// Contents: default width localparams (address, line, instruction, offset,
// index, tag, PID/TID, instruction counter) and the IDLE/MISS state type.
package l1i_cache_pkg;
   localparam int FETCH_ADDR_W = 64;
   localparam int LINE_W       = 512;
   localparam int INST_W       = 32;
   localparam int OFFSET_W     = 6;
   localparam int INDEX_W      = 8;
   localparam int TAG_W        = FETCH_ADDR_W - INDEX_W - OFFSET_W;
   localparam int PID_W        = 20;
   localparam int TID_W        = 16;
   localparam int ICNT_W       = 64;

   typedef enum logic {
      IDLE = 1'b0,
      MISS = 1'b1
   } state_t;
endpackage

// File: rtl/l1i_cache_array.sv
// l1i_cache_array -- direct-mapped tag/valid/line storage.
// Ports: i_clk/i_rst_n clock and async active-low reset (clears valid bits
//        only); i_rd_en/i_rd_idx registered read port -> o_rd_valid,
//        o_rd_tag, o_rd_line (frozen while i_rd_en=0); i_wr_en with two
//        write ports (idx/tag/line 0 and 1) used together for the dual-line
//        refill.
module l1i_cache_array
   import l1i_cache_pkg::*;
#(
   parameter int TAG_WIDTH   = TAG_W,
   parameter int INDEX_WIDTH = INDEX_W,
   parameter int LINE_WIDTH  = LINE_W
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_rd_en,
   input  logic [0:INDEX_WIDTH-1] i_rd_idx,
   output logic                   o_rd_valid,
   output logic [0:TAG_WIDTH-1]   o_rd_tag,
   output logic [0:LINE_WIDTH-1]  o_rd_line,
   input  logic                   i_wr_en,
   input  logic [0:INDEX_WIDTH-1] i_wr0_idx,
   input  logic [0:TAG_WIDTH-1]   i_wr0_tag,
   input  logic [0:LINE_WIDTH-1]  i_wr0_line,
   input  logic [0:INDEX_WIDTH-1] i_wr1_idx,
   input  logic [0:TAG_WIDTH-1]   i_wr1_tag,
   input  logic [0:LINE_WIDTH-1]  i_wr1_line
);
   localparam int DEPTH = 1 << INDEX_WIDTH;

   logic [DEPTH-1:0]      r_valid;
   logic [0:TAG_WIDTH-1]  r_tag  [DEPTH];
   logic [0:LINE_WIDTH-1] r_line [DEPTH];
   logic                  r_rd_valid;
   logic [0:TAG_WIDTH-1]  r_rd_tag;
   logic [0:LINE_WIDTH-1] r_rd_line;

   assign o_rd_valid = r_rd_valid;
   assign o_rd_tag   = r_rd_tag;
   assign o_rd_line  = r_rd_line;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid    <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         if (i_wr_en) begin
            r_valid[i_wr0_idx] <= 1'b1;
            r_valid[i_wr1_idx] <= 1'b1;
         end
         if (i_rd_en) r_rd_valid <= r_valid[i_rd_idx];
      end
   end

   // Tag and line contents carry no reset; valid bits alone qualify them.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_tag[i_wr0_idx]  <= i_wr0_tag;
         r_line[i_wr0_idx] <= i_wr0_line;
         r_tag[i_wr1_idx]  <= i_wr1_tag;
         r_line[i_wr1_idx] <= i_wr1_line;
      end
      if (i_rd_en) begin
         r_rd_tag  <= r_tag[i_rd_idx];
         r_rd_line <= r_line[i_rd_idx];
      end
   end
endmodule

// File: rtl/l1i_cache.sv
// l1i_cache -- direct-mapped L1 instruction cache, 3-stage fetch pipeline,
// two instructions per hit.
// Ports: clock_i, cacheReset_i (async active-low); fetch request
//        (fetchEnable_i, fetchStall_i, Pid_i, Tid_i, offset_i, index_i,
//        tag_i); refill (cacheUpdate_i, cacheUpdateAddress_i, Pid/Tid,
//        Line1/Line2); two fetch slots (fetchEnablen_o, fetchedInstructionn_o,
//        fetchedAddressn_o, fetchedPidn_o, fetchedTidn_o,
//        fetchedInstMajorIdn_o); miss report (cacheMiss_o, missedAddress_o,
//        missedInstMajorId_o, missedPid_o, missedTid_o).
// Stages: capture request -> array read -> compare and register outputs.
module l1i_cache
   import l1i_cache_pkg::*;
#(
   parameter int fetchingAddressWidth    = FETCH_ADDR_W,
   parameter int cacheLineWith           = LINE_W,
   parameter int instructionWidth        = INST_W,
   parameter int offsetWidth             = OFFSET_W,
   parameter int indexWidth              = INDEX_W,
   parameter int tagWidth                = fetchingAddressWidth - indexWidth - offsetWidth,
   parameter int PidSize                 = PID_W,
   parameter int TidSize                 = TID_W,
   parameter int instructionCounterWidth = ICNT_W
) (
   input  logic                                clock_i,
   input  logic                                cacheReset_i,
   input  logic                                fetchEnable_i,
   input  logic                                fetchStall_i,
   input  logic [0:PidSize-1]                  Pid_i,
   input  logic [0:TidSize-1]                  Tid_i,
   input  logic [0:offsetWidth-1]              offset_i,
   input  logic [0:indexWidth-1]               index_i,
   input  logic [0:tagWidth-1]                 tag_i,
   input  logic                                cacheUpdate_i,
   input  logic [0:fetchingAddressWidth-1]     cacheUpdateAddress_i,
   input  logic [0:PidSize-1]                  cacheUpdatePid_i,
   input  logic [0:TidSize-1]                  cacheUpdateTid_i,
   input  logic [0:cacheLineWith-1]            cacheUpdateLine1_i,
   input  logic [0:cacheLineWith-1]            cacheUpdateLine2_i,
   output logic                                fetchEnable1_o,
   output logic [0:instructionWidth-1]         fetchedInstruction1_o,
   output logic [0:fetchingAddressWidth-1]     fetchedAddress1_o,
   output logic [0:PidSize-1]                  fetchedPid1_o,
   output logic [0:TidSize-1]                  fetchedTid1_o,
   output logic [0:instructionCounterWidth-1]  fetchedInstMajorId1_o,
   output logic                                fetchEnable2_o,
   output logic [0:instructionWidth-1]         fetchedInstruction2_o,
   output logic [0:fetchingAddressWidth-1]     fetchedAddress2_o,
   output logic [0:PidSize-1]                  fetchedPid2_o,
   output logic [0:TidSize-1]                  fetchedTid2_o,
   output logic [0:instructionCounterWidth-1]  fetchedInstMajorId2_o,
   output logic                                cacheMiss_o,
   output logic [0:fetchingAddressWidth-1]     missedAddress_o,
   output logic [0:instructionCounterWidth-1]  missedInstMajorId_o,
   output logic [0:PidSize-1]                  missedPid_o,
   output logic [0:TidSize-1]                  missedTid_o
);
   localparam int STAGES = 2;
   localparam int WOFF_W = offsetWidth - 2;
   localparam logic [0:instructionCounterWidth-1] CNT_ONE  = instructionCounterWidth'(1);
   localparam logic [0:instructionCounterWidth-1] CNT_TWO  = instructionCounterWidth'(2);
   localparam logic [0:offsetWidth-1]             OFF_FOUR = offsetWidth'(4);
   localparam logic [0:fetchingAddressWidth-1]    ADR_FOUR = fetchingAddressWidth'(4);
   localparam logic [0:indexWidth-1]              IDX_ONE  = indexWidth'(1);
   localparam logic [0:tagWidth-1]                TAG_ONE  = tagWidth'(1);

   state_t                             r_state;
   logic [0:instructionCounterWidth-1] r_icnt;
   logic [STAGES:1]                    r_vld_pipe;  // [1] captured, [2] array read
   logic [0:PidSize-1]                 r_s1_pid, r_s2_pid;
   logic [0:TidSize-1]                 r_s1_tid, r_s2_tid;
   logic [0:WOFF_W-1]                  r_s1_woff, r_s2_woff;
   logic [0:indexWidth-1]              r_s1_idx, r_s2_idx;
   logic [0:tagWidth-1]                r_s1_tag, r_s2_tag;

   logic                               w_arr_valid;
   logic [0:tagWidth-1]                w_arr_tag;
   logic [0:cacheLineWith-1]           w_arr_line;
   logic                               w_adv, w_accept, w_hit, w_miss, w_slot2_ok;
   logic [0:offsetWidth-1]             w_off, w_off2;
   logic [0:offsetWidth+2]             w_bit1, w_bit2;
   logic [0:fetchingAddressWidth-1]    w_addr1;
   logic [0:indexWidth-1]              w_upd_idx;
   logic [0:tagWidth-1]                w_upd_tag;
   logic                               w_unused_ok;

   assign w_adv    = ~fetchStall_i;
   assign w_accept = fetchEnable_i & w_adv & (r_state == IDLE) & ~cacheUpdate_i;
   assign w_hit    = r_vld_pipe[2] & w_arr_valid & (w_arr_tag == r_s2_tag);
   assign w_miss   = r_vld_pipe[2] & ~w_hit;

   // Word-aligned byte offset; slot 2 exists unless off+4 wraps past the line end.
   assign w_off      = {r_s2_woff, 2'b00};
   assign w_off2     = w_off + OFF_FOUR;
   assign w_slot2_ok = (w_off2 != '0);
   assign w_bit1     = {w_off, 3'b000};
   assign w_bit2     = {w_off2, 3'b000};
   assign w_addr1    = {r_s2_tag, r_s2_idx, w_off};

   assign w_upd_idx   = cacheUpdateAddress_i[tagWidth +: indexWidth];
   assign w_upd_tag   = cacheUpdateAddress_i[0 +: tagWidth];
   assign w_unused_ok = ^{offset_i[WOFF_W +: 2], cacheUpdatePid_i, cacheUpdateTid_i,
                          cacheUpdateAddress_i[tagWidth+indexWidth +: offsetWidth]};

   // Second refill line belongs to the next index; crossing index wrap bumps the tag.
   l1i_cache_array #(
      .TAG_WIDTH   (tagWidth),
      .INDEX_WIDTH (indexWidth),
      .LINE_WIDTH  (cacheLineWith)
   ) u_array (
      .i_clk      (clock_i),
      .i_rst_n    (cacheReset_i),
      .i_rd_en    (w_adv),
      .i_rd_idx   (r_s1_idx),
      .o_rd_valid (w_arr_valid),
      .o_rd_tag   (w_arr_tag),
      .o_rd_line  (w_arr_line),
      .i_wr_en    (cacheUpdate_i),
      .i_wr0_idx  (w_upd_idx),
      .i_wr0_tag  (w_upd_tag),
      .i_wr0_line (cacheUpdateLine1_i),
      .i_wr1_idx  (w_upd_idx + IDX_ONE),
      .i_wr1_tag  ((w_upd_idx == '1) ? w_upd_tag + TAG_ONE : w_upd_tag),
      .i_wr1_line (cacheUpdateLine2_i)
   );

   // Request pipeline; a miss flushes everything queued behind it.
   always_ff @(posedge clock_i or negedge cacheReset_i) begin
      if (!cacheReset_i) begin
         r_vld_pipe <= '0;
         r_s1_pid <= '0; r_s1_tid <= '0; r_s1_woff <= '0; r_s1_idx <= '0; r_s1_tag <= '0;
         r_s2_pid <= '0; r_s2_tid <= '0; r_s2_woff <= '0; r_s2_idx <= '0; r_s2_tag <= '0;
      end else if (w_adv) begin
         r_vld_pipe <= w_miss ? '0 : {r_vld_pipe[1], w_accept};
         r_s1_pid  <= Pid_i;
         r_s1_tid  <= Tid_i;
         r_s1_woff <= offset_i[0 +: WOFF_W];
         r_s1_idx  <= index_i;
         r_s1_tag  <= tag_i;
         r_s2_pid  <= r_s1_pid;
         r_s2_tid  <= r_s1_tid;
         r_s2_woff <= r_s1_woff;
         r_s2_idx  <= r_s1_idx;
         r_s2_tag  <= r_s1_tag;
      end
   end

   // Compare stage: FSM, instruction counter and all registered outputs.
   always_ff @(posedge clock_i or negedge cacheReset_i) begin
      if (!cacheReset_i) begin
         r_state <= IDLE;
         r_icnt  <= '0;
         fetchEnable1_o <= 1'b0; fetchedInstruction1_o <= '0; fetchedAddress1_o <= '0;
         fetchedPid1_o  <= '0;   fetchedTid1_o <= '0;         fetchedInstMajorId1_o <= '0;
         fetchEnable2_o <= 1'b0; fetchedInstruction2_o <= '0; fetchedAddress2_o <= '0;
         fetchedPid2_o  <= '0;   fetchedTid2_o <= '0;         fetchedInstMajorId2_o <= '0;
         cacheMiss_o    <= 1'b0; missedAddress_o <= '0;       missedInstMajorId_o <= '0;
         missedPid_o    <= '0;   missedTid_o <= '0;
      end else begin
         fetchEnable1_o <= 1'b0;
         fetchEnable2_o <= 1'b0;
         cacheMiss_o    <= 1'b0;
         if (w_adv && w_hit) begin
            fetchEnable1_o        <= 1'b1;
            fetchedInstruction1_o <= w_arr_line[w_bit1 +: instructionWidth];
            fetchedAddress1_o     <= w_addr1;
            fetchedPid1_o         <= r_s2_pid;
            fetchedTid1_o         <= r_s2_tid;
            fetchedInstMajorId1_o <= r_icnt;
            if (w_slot2_ok) begin
               fetchEnable2_o        <= 1'b1;
               fetchedInstruction2_o <= w_arr_line[w_bit2 +: instructionWidth];
               fetchedAddress2_o     <= w_addr1 + ADR_FOUR;
               fetchedPid2_o         <= r_s2_pid;
               fetchedTid2_o         <= r_s2_tid;
               fetchedInstMajorId2_o <= r_icnt + CNT_ONE;
            end
            r_icnt <= r_icnt + (w_slot2_ok ? CNT_TWO : CNT_ONE);
         end else if (w_adv && w_miss) begin
            cacheMiss_o         <= 1'b1;
            missedAddress_o     <= w_addr1;
            missedInstMajorId_o <= r_icnt;
            missedPid_o         <= r_s2_pid;
            missedTid_o         <= r_s2_tid;
            r_state             <= MISS;
         end
         // A refill always reopens the cache, even against a same-cycle miss.
         if (cacheUpdate_i) r_state <= IDLE;
      end
   end
endmodule

// File: tb/tb_l1i_cache.sv
module tb_l1i_cache;
   logic          clk, rst_n;
   logic          fe, stall, upd;
   logic [0:19]   pid, upid, pid1, pid2, mpid;
   logic [0:15]   tid, utid, tid1, tid2, mtid;
   logic [0:5]    off;
   logic [0:7]    idx;
   logic [0:49]   tag;
   logic [0:63]   uaddr, a1, a2, maddr, id1, id2, mid;
   logic [0:511]  line1, line2;
   logic          en1, en2, miss;
   logic [0:31]   inst1, inst2;
   int            n_checks = 0;
   int            n_errors = 0;

   l1i_cache dut (
      .clock_i(clk), .cacheReset_i(rst_n),
      .fetchEnable_i(fe), .fetchStall_i(stall), .Pid_i(pid), .Tid_i(tid),
      .offset_i(off), .index_i(idx), .tag_i(tag),
      .cacheUpdate_i(upd), .cacheUpdateAddress_i(uaddr), .cacheUpdatePid_i(upid),
      .cacheUpdateTid_i(utid), .cacheUpdateLine1_i(line1), .cacheUpdateLine2_i(line2),
      .fetchEnable1_o(en1), .fetchedInstruction1_o(inst1), .fetchedAddress1_o(a1),
      .fetchedPid1_o(pid1), .fetchedTid1_o(tid1), .fetchedInstMajorId1_o(id1),
      .fetchEnable2_o(en2), .fetchedInstruction2_o(inst2), .fetchedAddress2_o(a2),
      .fetchedPid2_o(pid2), .fetchedTid2_o(tid2), .fetchedInstMajorId2_o(id2),
      .cacheMiss_o(miss), .missedAddress_o(maddr), .missedInstMajorId_o(mid),
      .missedPid_o(mpid), .missedTid_o(mtid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic fetch(input logic [49:0] t, input logic [7:0] i, input logic [5:0] o);
      fe = 1'b1; tag = t; idx = i; off = o;
   endtask

   task automatic idle();
      fe = 1'b0; upd = 1'b0;
   endtask

   task automatic exp_none(input string n);
      chk({n, ".en1"}, en1, 0);
      chk({n, ".en2"}, en2, 0);
      chk({n, ".miss"}, miss, 0);
   endtask

   task automatic exp_hit(input string n, input logic [31:0] i1, input logic [63:0] ad,
                          input logic [63:0] id, input logic e2, input logic [31:0] i2);
      chk({n, ".en1"}, en1, 1);
      chk({n, ".inst1"}, inst1, i1);
      chk({n, ".addr1"}, a1, ad);
      chk({n, ".id1"}, id1, id);
      chk({n, ".miss"}, miss, 0);
      chk({n, ".en2"}, en2, e2);
      if (e2) begin
         chk({n, ".inst2"}, inst2, i2);
         chk({n, ".addr2"}, a2, ad + 64'd4);
         chk({n, ".id2"}, id2, id + 64'd1);
      end
   endtask

   // Word k of the line = hex digit (A..F cycling) repeated.
   function automatic logic [0:511] pat_hex();
      logic [0:511] l;
      for (int k = 0; k < 16; k++) l[32*k +: 32] = 32'h11111111 * (32'hA + 32'(k % 6));
      return l;
   endfunction

   function automatic logic [0:511] pat_base(input logic [31:0] base);
      logic [0:511] l;
      for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
      return l;
   endfunction

   initial begin
      rst_n = 1'b0; fe = 1'b0; stall = 1'b0; upd = 1'b0;
      pid = 20'h12345; tid = 16'h0BEE; upid = '0; utid = '0;
      off = '0; idx = '0; tag = '0; uaddr = '0; line1 = '0; line2 = '0;
      #12;
      exp_none("rst");
      chk("rst.id1", id1, 0);
      chk("rst.maddr", maddr, 0);
      rst_n = 1'b1;
      step(); step();

      // Cold miss
      fetch(0, 0, 4); step();
      idle(); step(); step();
      chk("miss0.miss", miss, 1);
      chk("miss0.addr", maddr, 64'h4);
      chk("miss0.id", mid, 0);
      chk("miss0.pid", mpid, 20'h12345);
      chk("miss0.tid", mtid, 16'h0BEE);
      chk("miss0.en1", en1, 0);
      chk("miss0.en2", en2, 0);
      step();
      chk("miss0.pulse", miss, 0);

      // Fetch while in MISS is dropped
      fetch(0, 0, 4); step();
      idle(); step(); exp_none("inmiss1");
      step(); exp_none("inmiss2");
      step(); exp_none("inmiss3");

      // Refill index 0, then hit offset 8
      upd = 1'b1; uaddr = 64'h4; line1 = pat_hex(); line2 = pat_base(32'h3000_0000);
      step(); idle();
      fetch(0, 0, 8); step();
      idle(); step(); step();
      exp_hit("hit8", 32'hCCCCCCCC, 64'h8, 0, 1, 32'hDDDDDDDD);
      chk("hit8.pid2", pid2, 20'h12345);
      chk("hold.maddr", maddr, 64'h4);

      // Back-to-back hits
      fetch(0, 0, 16); step();
      fetch(0, 0, 24); step();
      fetch(0, 0, 32); step();
      exp_hit("hit16", 32'hEEEEEEEE, 64'h10, 2, 1, 32'hFFFFFFFF);
      idle(); step();
      exp_hit("hit24", 32'hAAAAAAAA, 64'h18, 4, 1, 32'hBBBBBBBB);
      step();
      exp_hit("hit32", 32'hCCCCCCCC, 64'h20, 6, 1, 32'hDDDDDDDD);
      step(); exp_none("b2b.end");

      // Last word of the line: no slot 2, counter +1 (offset 62 aligns to 60)
      fetch(0, 0, 62); step();
      idle(); step(); step();
      exp_hit("hit60", 32'hDDDDDDDD, 64'h3C, 8, 0, 32'h0);
      fetch(0, 0, 56); step();
      idle(); step(); step();
      exp_hit("hit56", 32'hCCCCCCCC, 64'h38, 9, 1, 32'hDDDDDDDD);

      // Refill at index 255: line2 lands at index 0 with tag+1
      upd = 1'b1; uaddr = 64'h17FC0; line1 = pat_base(32'h5000_0000);
      line2 = pat_base(32'h2000_0000);
      step(); idle();
      fetch(6, 0, 0); step();
      pid = 20'h00777; tid = 16'h0042;
      fetch(5, 255, 4); step();
      idle(); step();
      exp_hit("wrap.l2", 32'h20000000, 64'h18000, 11, 1, 32'h20000001);
      chk("wrap.l2.tid1", tid1, 16'h0BEE);
      step();
      exp_hit("wrap.l1", 32'h50000001, 64'h17FC4, 13, 1, 32'h50000002);
      chk("wrap.l1.pid2", pid2, 20'h00777);
      chk("wrap.l1.tid2", tid2, 16'h0042);

      // Stall two cycles mid-stream
      fetch(6, 0, 8); step();
      fetch(6, 0, 60); step();
      idle(); stall = 1'b1;
      step(); exp_none("stall1");
      step(); exp_none("stall2");
      stall = 1'b0;
      step(); exp_hit("post.a", 32'h20000002, 64'h18008, 15, 1, 32'h20000003);
      step(); exp_hit("post.b", 32'h2000000F, 64'h1803C, 17, 0, 32'h0);
      step(); exp_none("post.end");

      // Miss discards requests queued behind it
      fetch(0, 0, 12); step();
      fetch(6, 0, 0); step();
      fetch(6, 0, 4); step();
      chk("miss1.miss", miss, 1);
      chk("miss1.addr", maddr, 64'hC);
      chk("miss1.id", mid, 18);
      chk("miss1.en1", en1, 0);
      idle();
      step(); exp_none("flush1");
      step(); exp_none("flush2");
      step(); exp_none("flush3");

      // Refill wins over a same-cycle fetch and leaves MISS
      upd = 1'b1; uaddr = 64'h0; line1 = pat_hex(); line2 = pat_hex();
      fetch(0, 0, 0); step();
      idle();
      step(); exp_none("prio1");
      step(); exp_none("prio2");
      step(); exp_none("prio3");
      fetch(0, 0, 8); step();
      idle(); step(); step();
      exp_hit("refill", 32'hCCCCCCCC, 64'h8, 18, 1, 32'hDDDDDDDD);

      // Reset mid-stream
      fetch(0, 0, 0); step();
      fetch(0, 0, 4); step();
      idle(); step();
      exp_hit("prerst", 32'hAAAAAAAA, 64'h0, 20, 1, 32'hBBBBBBBB);
      #1 rst_n = 1'b0;
      #1;
      exp_none("midrst");
      chk("midrst.inst1", inst1, 0);
      chk("midrst.id1", id1, 0);
      chk("midrst.maddr", maddr, 0);
      step();
      rst_n = 1'b1;
      step(); exp_none("lost1");
      step(); exp_none("lost2");
      step(); exp_none("lost3");
      fetch(0, 0, 8); step();
      idle(); step(); step();
      chk("rstmiss.miss", miss, 1);
      chk("rstmiss.addr", maddr, 64'h8);
      chk("rstmiss.id", mid, 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/l1i_cache.md
L1I_CACHE -- requirements
Module: l1i_cache

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): fetchingAddressWidth 64 byte address; cacheLineWith 512 line bits; instructionWidth 32; offsetWidth 6 byte offset; indexWidth 8 (256 lines); tagWidth = fetchingAddressWidth-indexWidth-offsetWidth (50); PidSize 20; TidSize 16; instructionCounterWidth 64.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; all vectors SHALL be big-endian [0:W-1].
REQ-003 clock_i  in  1  rising-edge clock.
REQ-004 cacheReset_i  in  1  asynchronous active-low reset.
REQ-005 Fetch inputs: fetchEnable_i 1 request valid; fetchStall_i 1 pipeline hold; Pid_i PidSize; Tid_i TidSize; offset_i offsetWidth; index_i indexWidth; tag_i tagWidth.
REQ-006 Update inputs: cacheUpdate_i 1; cacheUpdateAddress_i fetchingAddressWidth; cacheUpdatePid_i PidSize; cacheUpdateTid_i TidSize; cacheUpdateLine1_i, cacheUpdateLine2_i cacheLineWith.
REQ-007 Fetch outputs, slots n=1,2: fetchEnablen_o 1; fetchedInstructionn_o instructionWidth; fetchedAddressn_o fetchingAddressWidth; fetchedPidn_o PidSize; fetchedTidn_o TidSize; fetchedInstMajorIdn_o instructionCounterWidth.
REQ-008 Miss outputs: cacheMiss_o 1; missedAddress_o fetchingAddressWidth; missedInstMajorId_o instructionCounterWidth; missedPid_o PidSize; missedTid_o TidSize.

Function
REQ-009 Storage SHALL be direct-mapped: 256 entries of {valid, tag, 512-bit line}.
REQ-010 A request SHALL be accepted on a rising edge with fetchEnable_i=1, fetchStall_i=0, block not in MISS state, cacheUpdate_i=0; all other requests SHALL be dropped.
REQ-011 Pipeline SHALL be 3 stages: edge N capture request; edge N+1 read tag/valid/line at index; edge N+2 compare and register outputs; fully pipelined, one request per cycle.
REQ-012 Hit (valid and stored tag == tag_i): slot1 SHALL carry line bits [8*off : 8*off+31], off = offset_i with low 2 bits forced 0; address {tag,index,off}.
REQ-013 Slot2 SHALL carry the word at off+4 and address+4 when off<=56; otherwise fetchEnable2_o=0 (no line crossing).
REQ-014 Both slots SHALL carry the request's Pid/Tid; slot1 major ID = counter, slot2 = counter+1; counter SHALL advance by the number of slots issued.
REQ-015 Miss: for one cycle cacheMiss_o=1 with missedAddress_o={tag,index,off}, missedPid_o/missedTid_o of the request, missedInstMajorId_o=counter; both enables 0; state SHALL become MISS.
REQ-016 In MISS state, new requests SHALL be dropped and no further miss reported; requests already in flight behind the miss SHALL be discarded.
REQ-017 Update on an edge with cacheUpdate_i=1: line1 written to index i of cacheUpdateAddress_i with its tag; line2 written to index (i+1) mod 256 with tag+1 when i=255, else same tag; both valid; state SHALL return to IDLE.
REQ-018 An update SHALL take priority over a fetch in the same cycle; the fetch is dropped.
REQ-019 fetchStall_i=1 SHALL freeze all pipeline registers and force all enables and cacheMiss_o to 0 for that cycle.
REQ-020 All enable/miss outputs SHALL be single-cycle pulses; data outputs hold last value when enables are 0.

Reset
REQ-021 Asserting cacheReset_i low SHALL asynchronously clear all valid bits, pipeline valids, counter (0), state (IDLE) and every output to 0; line/tag data need not reset.
REQ-022 A request in flight when reset asserts SHALL be lost without any output.

Structure
REQ-023 Width parameters and the state encoding (IDLE, MISS) SHALL live in shared package l1i_cache_pkg.
REQ-024 The tag/valid/data storage SHALL be one sub-module l1i_cache_array (1 read port, 2 write ports for the dual-line update).

Verification
REQ-025 Reset, fetch tag0/index0/offset4 -> two edges later cacheMiss_o=1 for one cycle, missedAddress_o=0x4, missedInstMajorId_o=0, enables 0.
REQ-026 Second fetch tag0/index0 while in MISS -> no enables, no new miss.
REQ-027 Update address 0x4, line1=AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_..., then fetch offset 8 -> inst1=0xCCCCCCCC addr 0x8 ID0, inst2=0xDDDDDDDD addr 0xC ID1.
REQ-028 Back-to-back fetches offsets 16, 24, 32 -> one hit per cycle: (EEEEEEEE,FFFFFFFF), (AAAAAAAA,BBBBBBBB), (CCCCCCCC,DDDDDDDD), IDs 2..7.
REQ-029 Offset 60 hit -> slot1 word 15 valid, fetchEnable2_o=0, counter +1; update at index 255 -> line2 hits at index 0 with tag+1.
REQ-030 fetchStall_i held high 2 cycles mid-stream -> outputs 0 during stall, sequence resumes unchanged afterward; reset mid-stream -> all outputs 0 immediately.
